instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch (IF) stage of the pipelined MIPS core. Holds the program counter and drives the instruction memory address. Captures the returned instruction word into the IF/ID pipeline register. Applies stall, flush, redirect and exception-vector requests from later stages, plus an optional branch target buffer (BTB) with 2-bit predictors.

## Interface

**Parameters**

- `StartPC`, default `32'h0`: PC value loaded on reset.
- `ExcVector`, default `32'hF0000000`: PC loaded on an exception.
- `BTBEntries`, default `16`: number of BTB entries. Must be a power of 2, at least 2.

**Ports** (name, direction, width, meaning)

- `CLK`, in, 1: clock. All state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `InstrAddr`, out, 32: address to instruction memory. Equals the PC register.
- `InstrData`, in, 32: combinational read data from instruction memory.
- `Stall`, in, 1: hold PC and IF/ID.
- `Flush`, in, 1: load a bubble into IF/ID.
- `Redirect`, in, 1: next PC comes from `RedirectPC`. Used for resolved branch, jump, jr, or mispredict correction.
- `RedirectPC`, in, 32: redirect target.
- `Exception`, in, 1: next PC is `ExcVector`.
- `ResolveValid`, in, 1: a branch resolved this cycle; used to update the BTB.
- `ResolvePC`, in, 32: address of the resolved branch.
- `ResolveTaken`, in, 1: actual branch outcome.
- `ResolveTarget`, in, 32: actual taken target.
- `IFID_Instr`, out, 32: fetched instruction.
- `IFID_PC`, out, 32: address of `IFID_Instr`.
- `IFID_PCPlus4`, out, 32: `IFID_PC + 4`.
- `IFID_Valid`, out, 1: IF/ID holds a real instruction.
- `IFID_PredTaken`, out, 1: fetch predicted taken.
- `IFID_PredTarget`, out, 32: predicted target. 0 when not predicted taken.

## Operation

**Next-PC selection.** Evaluated every cycle, highest priority first:
1. `Reset`: PC <= `StartPC`.
2. `Exception`: PC <= `ExcVector`.
3. `Redirect`: PC <= `RedirectPC`.
4. `Stall`: PC holds.
5. BTB hit and predict-taken: PC <= BTB target.
6. Otherwise: PC <= PC + 4. Wraps modulo 2^32.

**IF/ID register update.** Highest priority first:
1. `Reset`, `Exception`, `Redirect` or `Flush`: load a bubble. Bubble = Instr `32'h0` (nop), Valid 0, PC 0, PCPlus4 0, PredTaken 0, PredTarget 0.
2. `Stall`: hold all fields.
3. Otherwise: capture `InstrData`, PC, PC+4, the prediction, and Valid = 1.

**Redirect/flush interactions.**
- `Redirect` or `Exception` overrides `Stall`: the PC moves and IF/ID gets a bubble.
- `Flush` with `Stall`: the bubble wins and the PC holds.
- An X or undefined `InstrData` is only ever captured into a non-bubble slot. Bubbles are always 0.

**BTB** (only when `BRANCH_PREDICT_EN` is defined):
- Direct-mapped. Index = PC[log2(BTBEntries)+1:2]. Tag = remaining PC[31:log2(BTBEntries)+2].
- Each entry holds: valid, tag, 32-bit target, 2-bit saturating counter.
- Lookup on the current PC is combinational. Predict taken = valid & tag match & counter[1].
- Update on `ResolveValid`, indexed by `ResolvePC`:
  - On hit: counter increments if taken, decrements if not, saturating at 3 and 0. Target is rewritten when taken.
  - On miss with taken: allocate entry with tag, target, counter = 2.
  - On miss with not-taken: no change.
- A lookup and an update to the same index in the same cycle: the lookup sees the old contents. The update is visible from the next cycle.
- Reset clears all valid bits; counters and targets are don't-care.
- An update proceeds regardless of `Stall`, `Flush`, `Redirect` or `Exception`.
- Stage outputs `IFID_PredTaken`/`IFID_PredTarget`. Mispredict detection and correction belong to the downstream stage, which drives `Redirect`.

## Timing

- Reset values: PC = `StartPC`, so `InstrAddr` = `StartPC`. All IF/ID fields are 0 and `IFID_Valid` = 0.
- The fetch of a given PC appears in IF/ID on the edge after that PC is on `InstrAddr`: 1-cycle latency. Memory read completes within the cycle.
- Redirect penalty: the cycle after `Redirect`, IF/ID holds a bubble and `InstrAddr` = `RedirectPC`. The target instruction reaches IF/ID one cycle later.
- Correct taken prediction: zero bubbles.
- `Reset` asserted mid-stream takes effect at the next edge regardless of any other input.

## Configuration

- `BRANCH_PREDICT_EN` defined: BTB and predictor are built as described under Operation.
- Not defined:
  - No BTB storage.
  - Prediction is always not-taken: `IFID_PredTaken` = 0, `IFID_PredTarget` = 0.
  - `ResolveValid`/`ResolvePC`/`ResolveTaken`/`ResolveTarget` are ignored.
  - Next PC is PC + 4 unless `Reset`, `Exception`, `Redirect` or `Stall` applies.

## Test plan

- **Sequential fetch.** `StartPC` = 0, release reset, 3 cycles.
  - Required: IF/ID shows 0x34080032 @0x0, then 0xac080000 @0x4, then 0x34080028 @0x8, Valid = 1.
  - `IFID_PCPlus4` = 0x4, 0x8, 0xC.
- **Stall.** `Stall` for 2 cycles while IF/ID holds @0x8.
  - Required: IF/ID and `InstrAddr` (0xC) unchanged for both cycles.
  - Required: 0xac080004 @0xC captured on the first cycle after release.
- **Redirect (jr).** `Redirect` = 1, `RedirectPC` = 0x190, with `Stall` = 1 in the same cycle.
  - Required: next cycle has IF/ID bubble (Valid 0, Instr 0) and `InstrAddr` = 0x190.
  - Required: following cycle IF/ID = 0xac090054 @0x190.
- **Exception priority.** `Exception` + `Redirect` (→0x300) + `Flush` in the same cycle.
  - Required: `InstrAddr` = 0xF0000000.
  - Required: one cycle later IF/ID = 0x8c080000 @0xF0000000.
- **Predictor** (macro on). `ResolveValid` with `ResolvePC` = 0x51C, taken, `ResolveTarget` = 0x514. Then fetch 0x51C.
  - Required: `IFID_PredTaken` = 1, `IFID_PredTarget` = 0x514, next `InstrAddr` = 0x514.
  - Then two not-taken resolves at 0x51C. Required: the next fetch of 0x51C predicts not-taken and the next PC is 0x520.
- **Predictor off** (macro off). Same stimulus as the predictor scenario.
  - Required: `IFID_PredTaken` = 0 and next `InstrAddr` = 0x520.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Instruction fetch stage of the pipelined MIPS core. It holds the program
// counter, drives the instruction memory address, and captures the returned
// instruction into the IF/ID pipeline register. It also applies the stall,
// flush, redirect and exception requests that come from later stages.
//
// Optional feature: define BRANCH_PREDICT_EN to build a direct-mapped branch
// target buffer with 2-bit saturating predictors. When the macro is not
// defined, fetch always predicts not-taken and the resolve inputs are unused.
//
// BTBEntries must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] StartPC    = 32'h0,
    parameter logic [31:0] ExcVector  = 32'hF000_0000,
    parameter int          BTBEntries = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] InstrAddr,
    input  logic [31:0] InstrData,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Exception,
    input  logic        ResolveValid,
    input  logic [31:0] ResolvePC,
    input  logic        ResolveTaken,
    input  logic [31:0] ResolveTarget,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        IFID_PredTaken,
    output logic [31:0] IFID_PredTarget
);

    // -------------------------------------------------------------------------
    // Program counter and IF/ID pipeline state
    // -------------------------------------------------------------------------
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;

    logic [31:0] ifid_instr_q,       ifid_instr_d;
    logic [31:0] ifid_pc_q,          ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q,    ifid_pc_plus4_d;
    logic        ifid_valid_q,       ifid_valid_d;
    logic        ifid_pred_taken_q,  ifid_pred_taken_d;
    logic [31:0] ifid_pred_target_q, ifid_pred_target_d;

    // Prediction for the instruction currently being fetched (at pc_q).
    logic        pred_taken;
    logic [31:0] pred_target;

    // Sequential successor; wraps modulo 2^32 naturally.
    assign pc_plus4 = pc_q + 32'd4;

`ifdef BRANCH_PREDICT_EN
    // -------------------------------------------------------------------------
    // Branch target buffer
    // -------------------------------------------------------------------------
    localparam int IdxW = $clog2(BTBEntries);
    localparam int TagW = 30 - IdxW;

    // Valid bits need a reset, so they live in flops; tag, target and counter
    // carry no reset and are kept in plain arrays.
    logic [BTBEntries-1:0] btb_valid_q;
    logic [TagW-1:0]       btb_tag_q    [BTBEntries];
    logic [31:0]           btb_target_q [BTBEntries];
    logic [1:0]            btb_ctr_q    [BTBEntries];

    // Lookup side, addressed by the current PC.
    logic [IdxW-1:0] look_idx;
    logic [TagW-1:0] look_tag;
    logic            look_hit;

    // Update side, addressed by the resolving branch.
    logic [IdxW-1:0] res_idx;
    logic [TagW-1:0] res_tag;
    logic            res_hit;
    logic [1:0]      res_ctr_cur;

    // Write port data for the entry selected by res_idx.
    logic            btb_wr_en;
    logic [TagW-1:0] btb_tag_d;
    logic [31:0]     btb_target_d;
    logic [1:0]      btb_ctr_d;

    // The two low PC bits never participate in indexing or tagging.
    logic unused_resolve_lsb;
    assign unused_resolve_lsb = ^ResolvePC[1:0];

    assign look_idx = pc_q[IdxW+1:2];
    assign look_tag = pc_q[31:IdxW+2];
    assign res_idx  = ResolvePC[IdxW+1:2];
    assign res_tag  = ResolvePC[31:IdxW+2];

    // Combinational lookup on the current PC; a same-cycle update to the same
    // entry only lands at the clock edge, so the lookup always sees old data.
    always_comb begin
        look_hit    = btb_valid_q[look_idx] && (btb_tag_q[look_idx] == look_tag);
        pred_taken  = look_hit && btb_ctr_q[look_idx][1];
        pred_target = pred_taken ? btb_target_q[look_idx] : 32'h0;
    end

    // Compute the training write for a resolved branch: saturating counter on
    // a hit, fresh weakly-taken allocation on a taken miss, nothing otherwise.
    always_comb begin
        res_hit      = btb_valid_q[res_idx] && (btb_tag_q[res_idx] == res_tag);
        res_ctr_cur  = btb_ctr_q[res_idx];
        btb_wr_en    = 1'b0;
        btb_tag_d    = res_tag;
        btb_target_d = btb_target_q[res_idx];
        btb_ctr_d    = res_ctr_cur;
        if (ResolveValid) begin
            if (res_hit) begin
                btb_wr_en = 1'b1;
                if (ResolveTaken) begin
                    btb_ctr_d    = (res_ctr_cur == 2'b11) ? 2'b11 : res_ctr_cur + 2'd1;
                    btb_target_d = ResolveTarget;
                end else begin
                    btb_ctr_d    = (res_ctr_cur == 2'b00) ? 2'b00 : res_ctr_cur - 2'd1;
                end
            end else if (ResolveTaken) begin
                btb_wr_en    = 1'b1;
                btb_ctr_d    = 2'b10;
                btb_target_d = ResolveTarget;
            end
        end
    end

    // One valid flop per entry: cleared by reset, set when the entry is written.
    genvar gi;
    generate
        for (gi = 0; gi < BTBEntries; gi++) begin : g_btb_valid
            always_ff @(posedge CLK) begin
                if (Reset) begin
                    btb_valid_q[gi] <= 1'b0;
                end else if (btb_wr_en && (res_idx == IdxW'(gi))) begin
                    btb_valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Entry payload write; independent of stall/flush/redirect/exception.
    always_ff @(posedge CLK) begin
        if (btb_wr_en) begin
            btb_tag_q[res_idx]    <= btb_tag_d;
            btb_target_q[res_idx] <= btb_target_d;
            btb_ctr_q[res_idx]    <= btb_ctr_d;
        end
    end
`else
    // Without a BTB every fetch is predicted not-taken.
    logic unused_resolve;
    assign unused_resolve = ^{ResolveValid, ResolvePC, ResolveTaken, ResolveTarget};

    // Static not-taken prediction.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = 32'h0;
    end
`endif

    // -------------------------------------------------------------------------
    // Next-PC selection: exception, then redirect, then stall, then prediction.
    // Reset is applied in the register process and overrides all of these.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d = pc_plus4;
        if (Exception) begin
            pc_d = ExcVector;
        end else if (Redirect) begin
            pc_d = RedirectPC;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // IF/ID next state: bubble on any control-flow change or flush, hold on
    // stall, otherwise capture the instruction fetched at the current PC.
    always_comb begin
        ifid_instr_d       = ifid_instr_q;
        ifid_pc_d          = ifid_pc_q;
        ifid_pc_plus4_d    = ifid_pc_plus4_q;
        ifid_valid_d       = ifid_valid_q;
        ifid_pred_taken_d  = ifid_pred_taken_q;
        ifid_pred_target_d = ifid_pred_target_q;
        if (Exception || Redirect || Flush) begin
            // Bubble fields are constants, so undefined memory data never
            // reaches an invalid slot.
            ifid_instr_d       = 32'h0;
            ifid_pc_d          = 32'h0;
            ifid_pc_plus4_d    = 32'h0;
            ifid_valid_d       = 1'b0;
            ifid_pred_taken_d  = 1'b0;
            ifid_pred_target_d = 32'h0;
        end else if (!Stall) begin
            ifid_instr_d       = InstrData;
            ifid_pc_d          = pc_q;
            ifid_pc_plus4_d    = pc_plus4;
            ifid_valid_d       = 1'b1;
            ifid_pred_taken_d  = pred_taken;
            ifid_pred_target_d = pred_target;
        end
    end

    // PC and IF/ID registers with synchronous reset to StartPC / bubble.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q               <= StartPC;
            ifid_instr_q       <= 32'h0;
            ifid_pc_q          <= 32'h0;
            ifid_pc_plus4_q    <= 32'h0;
            ifid_valid_q       <= 1'b0;
            ifid_pred_taken_q  <= 1'b0;
            ifid_pred_target_q <= 32'h0;
        end else begin
            pc_q               <= pc_d;
            ifid_instr_q       <= ifid_instr_d;
            ifid_pc_q          <= ifid_pc_d;
            ifid_pc_plus4_q    <= ifid_pc_plus4_d;
            ifid_valid_q       <= ifid_valid_d;
            ifid_pred_taken_q  <= ifid_pred_taken_d;
            ifid_pred_target_q <= ifid_pred_target_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign InstrAddr       = pc_q;
    assign IFID_Instr      = ifid_instr_q;
    assign IFID_PC         = ifid_pc_q;
    assign IFID_PCPlus4    = ifid_pc_plus4_q;
    assign IFID_Valid      = ifid_valid_q;
    assign IFID_PredTaken  = ifid_pred_taken_q;
    assign IFID_PredTarget = ifid_pred_target_q;

endmodule
